clock_mode_ctrl: RTL

Mode controller for the 24 h wall clock. It sequences the clock through run, time-set and alarm-set modes and routes single-cycle button pulses and the 1 Hz tick to the correct counter (time or alarm, hours or minutes). It also drives the display source select and per-digit blink mask for the seven-segment driver. It sits between the Debounce/Delay_Reset front end and the time/alarm BCD counters.

---
 rtl/clock_mode_ctrl_if.sv | 27 ++
 rtl/clock_mode_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button/tick inputs and counter/display controls of the clock mode controller
interface clock_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       sec_tick;
    logic       tick_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_secs;
    logic       alm_inc_hour;
    logic       alm_inc_min;
    logic       disp_sel;
    logic [3:0] blank_mask;
    logic [2:0] mode;

    modport master (
        output btn_mode, btn_up, sec_tick,
        input  tick_en, inc_hour, inc_min, clr_secs, alm_inc_hour, alm_inc_min,
               disp_sel, blank_mask, mode
    );

    modport slave (
        input  btn_mode, btn_up, sec_tick,
        output tick_en, inc_hour, inc_min, clr_secs, alm_inc_hour, alm_inc_min,
               disp_sel, blank_mask, mode
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - run/time-set/alarm-set sequencer with pulse routing, idle timeout and digit blink
module clock_mode_ctrl #(
    parameter int BLINK_CYCLES = 50000000,
    parameter int TIMEOUT_S    = 10
) (
    input logic              CLK100MHZ,
    input logic              reset,
    clock_mode_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        ALM_HR  = 3'd3,
        ALM_MIN = 3'd4
    } state_t;

    localparam int            CW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
    localparam logic [4:0]    IDLE_LAST  = 5'(TIMEOUT_S - 1);

    state_t        r_state;
    logic [4:0]    r_idle_s;
    logic [CW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic          r_tick_en;
    logic          r_inc_hour;
    logic          r_inc_min;
    logic          r_clr_secs;
    logic          r_alm_inc_hour;
    logic          r_alm_inc_min;
    logic          r_disp_sel;
    logic [3:0]    r_blank_mask;

    state_t     w_next_state;
    logic       w_up;
    logic       w_timeout;
    logic       w_state_change;
    logic       w_blink_restart;
    logic       w_blink_wrap;
    logic       w_next_phase;
    logic [3:0] w_next_mask;

    always_comb begin
        w_next_state = r_state;
        // btn_mode wins over btn_up in the same cycle, and any button defeats the timeout
        w_up      = bus.btn_up && !bus.btn_mode;
        w_timeout = (r_state != RUN) && bus.sec_tick && (r_idle_s == IDLE_LAST)
                    && !bus.btn_mode && !bus.btn_up;
        case (r_state)
            RUN:     if (bus.btn_mode) w_next_state = SET_HR;
            SET_HR:  if (bus.btn_mode) w_next_state = SET_MIN;
            SET_MIN: if (bus.btn_mode) w_next_state = ALM_HR;
            ALM_HR:  if (bus.btn_mode) w_next_state = ALM_MIN;
            ALM_MIN: if (bus.btn_mode) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
        if (w_timeout) w_next_state = RUN;
        w_state_change  = (w_next_state != r_state);
        w_blink_restart = w_state_change || bus.btn_up;
        w_blink_wrap    = (r_blink_cnt == BLINK_LAST);
        w_next_phase    = w_blink_restart ? 1'b1 : (w_blink_wrap ? ~r_blink_phase : r_blink_phase);
        case (w_next_state)
            SET_HR, ALM_HR:   w_next_mask = {{2{~w_next_phase}}, 2'b00};
            SET_MIN, ALM_MIN: w_next_mask = {2'b00, {2{~w_next_phase}}};
            default:          w_next_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state        <= RUN;
            r_idle_s       <= '0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b1;
            r_tick_en      <= 1'b0;
            r_inc_hour     <= 1'b0;
            r_inc_min      <= 1'b0;
            r_clr_secs     <= 1'b0;
            r_alm_inc_hour <= 1'b0;
            r_alm_inc_min  <= 1'b0;
            r_disp_sel     <= 1'b0;
            r_blank_mask   <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == RUN || bus.btn_mode || bus.btn_up || w_state_change)
                r_idle_s <= '0;
            else if (bus.sec_tick)
                r_idle_s <= r_idle_s + 5'd1;
            r_blink_cnt    <= (w_blink_restart || w_blink_wrap) ? '0 : r_blink_cnt + CW'(1);
            r_blink_phase  <= w_next_phase;
            // time is frozen while either time field is being edited
            r_tick_en      <= bus.sec_tick && (r_state == RUN || r_state == ALM_HR || r_state == ALM_MIN);
            r_inc_hour     <= w_up && (r_state == SET_HR);
            r_inc_min      <= w_up && (r_state == SET_MIN);
            r_clr_secs     <= (r_state == SET_MIN) && (w_up || w_next_state != SET_MIN);
            r_alm_inc_hour <= w_up && (r_state == ALM_HR);
            r_alm_inc_min  <= w_up && (r_state == ALM_MIN);
            r_disp_sel     <= (w_next_state == ALM_HR) || (w_next_state == ALM_MIN);
            r_blank_mask   <= w_next_mask;
        end
    end

    assign bus.mode         = r_state;
    assign bus.tick_en      = r_tick_en;
    assign bus.inc_hour     = r_inc_hour;
    assign bus.inc_min      = r_inc_min;
    assign bus.clr_secs     = r_clr_secs;
    assign bus.alm_inc_hour = r_alm_inc_hour;
    assign bus.alm_inc_min  = r_alm_inc_min;
    assign bus.disp_sel     = r_disp_sel;
    assign bus.blank_mask   = r_blank_mask;
endmodule
